// File: rtl/sd_frame_controller.sv
// sd_frame_controller: sequences an external non-overlapping Moore detector
// (pattern 110101) over fixed-length serial frames.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   start                 request a frame (honoured only in IDLE)
//   abort                 cancel the active frame without a done pulse
//   bit_in, bit_valid     serial bit source
//   in_ready              controller accepts bits (WAIT or RUN)
//   det_x, det_rst, det_y detector stimulus, registered reset, detector output
//   busy                  frame in progress (WAIT, RUN, DRAIN)
//   done                  one-cycle pulse on frame completion or gap
//   err                   sticky gap flag for the current/last frame
//   match_count           saturating detector hits for the current/last frame
module sd_frame_controller #(
  parameter int unsigned FRAME_LEN = 12,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             in_ready,
  output logic             det_x,
  output logic             det_rst,
  input  logic             det_y,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned BCNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_d;
  logic              det_rst_d, done_d, err_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [BCNT_W-1:0] bit_cnt, bit_cnt_d;

  // Status decoded directly from the state register.
  assign in_ready = (state == WAIT) || (state == RUN);
  assign busy     = (state != IDLE);
  assign det_x    = bit_in & bit_valid & in_ready;

  // State and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      det_rst     <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      match_count <= '0;
      bit_cnt     <= '0;
    end else begin
      state       <= state_d;
      det_rst     <= det_rst_d;
      done        <= done_d;
      err         <= err_d;
      match_count <= cnt_d;
      bit_cnt     <= bit_cnt_d;
    end
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d   = state;
    det_rst_d = det_rst;
    done_d    = 1'b0;
    err_d     = err;
    cnt_d     = match_count;
    bit_cnt_d = bit_cnt;

    // det_y reflects the bit consumed on the previous edge, so it is only
    // meaningful once a bit has gone in (RUN, and the final bit in DRAIN).
    if (((state == RUN) || (state == DRAIN)) && det_y && (match_count != CNT_MAX)) begin
      cnt_d = match_count + CNT_W'(1);
    end

    unique case (state)
      IDLE: begin
        det_rst_d = 1'b1;
        if (start) begin
          det_rst_d = 1'b0;
          cnt_d     = '0;
          err_d     = 1'b0;
          bit_cnt_d = '0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          det_rst_d = 1'b1;
          state_d   = IDLE;
        end else if (bit_valid) begin
          bit_cnt_d = BCNT_W'(1);
          state_d   = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          det_rst_d = 1'b1;
          state_d   = IDLE;
        end else if (bit_valid) begin
          bit_cnt_d = bit_cnt + BCNT_W'(1);
          if (bit_cnt == LAST_IDX) begin
            state_d = DRAIN;
          end
        end else begin
          // Stream gap: terminate the frame with an error.
          err_d     = 1'b1;
          done_d    = 1'b1;
          det_rst_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DRAIN: begin
        det_rst_d = 1'b1;
        state_d   = IDLE;
        done_d    = ~abort;
      end
      default: begin
        det_rst_d = 1'b1;
        state_d   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_frame_controller.sv
// Testbench for sd_frame_controller: a behavioural detector model drives det_y,
// and expected hit counts come from a greedy non-overlapping pattern scan.
module tb_sd_frame_controller;

  localparam int unsigned FL = 12;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset, start, abort, bit_in, bit_valid;
  logic          in_ready, det_x, det_rst, busy, done, err;
  logic          det_y = 1'b0;
  logic [CW-1:0] match_count;

  int checks = 0;
  int errors = 0;

  logic fb [0:FL-1];

  sd_frame_controller #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .bit_in(bit_in), .bit_valid(bit_valid), .in_ready(in_ready),
    .det_x(det_x), .det_rst(det_rst), .det_y(det_y), .busy(busy),
    .done(done), .err(err), .match_count(match_count)
  );

  always #5 clk = ~clk;

  // Detector model: output high in the cycle after the last bit of 110101
  // counted over bits since reset or since the previous hit.
  int unsigned dn = 0;
  logic [5:0]  dh = 6'd0;
  int unsigned nn;
  logic [5:0]  nh;
  always @(posedge clk) begin
    if (det_rst) begin
      dn    <= 0;
      dh    <= 6'd0;
      det_y <= 1'b0;
    end else begin
      nh = det_y ? {5'd0, det_x} : {dh[4:0], det_x};
      nn = (det_y ? 0 : dn) + 1;
      if (nn > 6) nn = 6;
      if (nn == 6 && nh == 6'b110101) begin
        det_y <= 1'b1;
        dn    <= 0;
        dh    <= 6'd0;
      end else begin
        det_y <= 1'b0;
        dn    <= nn;
        dh    <= nh;
      end
    end
  end

  // Expected hits among the first n frame bits.
  function automatic int exp_count(input int n);
    int c = 0;
    int i = 0;
    logic [5:0] w;
    while (i + 6 <= n) begin
      for (int k = 0; k < 6; k++) w[5-k] = fb[i+k];
      if (w == 6'b110101) begin
        c++;
        i += 6;
      end else begin
        i++;
      end
    end
    return c;
  endfunction

  task automatic load_frame(input logic [FL-1:0] v);
    for (int i = 0; i < FL; i++) fb[i] = v[FL-1-i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full frame starting in IDLE; ends in the done cycle.
  task automatic run_frame(input logic [FL-1:0] v, input int idles, input int poke);
    load_frame(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || det_rst !== 1'b0) begin
      errors++;
      $display("FAIL frame_start busy=%b in_ready=%b det_rst=%b want 1 1 0", busy, in_ready, det_rst);
    end
    checks++;
    if (match_count !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL frame_clear match_count=%0d err=%b want 0 0", match_count, err);
    end
    for (int k = 0; k < idles; k++) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      #1;
      checks++;
      if (det_x !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL wait_idle det_x=%b in_ready=%b want 0 1", det_x, in_ready);
      end
      tick();
    end
    for (int i = 0; i < int'(FL); i++) begin
      bit_valid = 1'b1;
      bit_in    = fb[i];
      start     = (i == poke);
      #1;
      checks++;
      if (det_x !== fb[i]) begin
        errors++;
        $display("FAIL det_x bit %0d got %b want %b", i, det_x, fb[i]);
      end
      tick();
      start = 1'b0;
    end
    bit_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain busy=%b done=%b in_ready=%b want 1 0 0", busy, done, in_ready);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || det_rst !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL frame_end done=%b busy=%b det_rst=%b err=%b want 1 0 1 0", done, busy, det_rst, err);
    end
    checks++;
    if (match_count !== CW'(exp_count(FL))) begin
      errors++;
      $display("FAIL match_count frame %b got %0d want %0d", v, match_count, exp_count(FL));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
    tick();
    checks++;
    if (det_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0 || match_count !== '0) begin
      errors++;
      $display("FAIL reset_regs det_rst=%b done=%b err=%b mc=%0d want 1 0 0 0", det_rst, done, err, match_count);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || det_x !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs busy=%b in_ready=%b det_x=%b want 0 0 0", busy, in_ready, det_x);
    end
    reset = 1'b0; bit_valid = 1'b0;
    tick();
  endtask

  task automatic test_frames();
    run_frame(12'b110101110101, 0, -1);
    checks++;
    if (match_count !== 8'd2) begin
      errors++;
      $display("FAIL two_hits got %0d want 2", match_count);
    end
    run_frame(12'b000000110101, 0, -1);
    run_frame(12'b110101010101, 0, -1);
    run_frame(12'b111101011010, 0, -1);
    run_frame(12'b110101000000, 3, 4);
    tick();
    checks++;
    if (done !== 1'b0 || match_count !== 8'd1) begin
      errors++;
      $display("FAIL done_drop done=%b mc=%0d want 0 1", done, match_count);
    end
  endtask

  task automatic test_random();
    logic [FL-1:0] v;
    int o;
    for (int n = 0; n < 20; n++) begin
      v = FL'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        o = int'($urandom_range(FL - 6, 0));
        v[FL-1-o -: 6] = 6'b110101;
      end
      run_frame(v, int'($urandom_range(3, 0)),
                ($urandom_range(1, 0) == 1) ? int'($urandom_range(FL - 1, 1)) : -1);
    end
    tick();
  endtask

  task automatic test_gap();
    load_frame(12'b110101000000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'b1; bit_in = fb[i];
      tick();
    end
    bit_valid = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1 || done !== 1'b1 || det_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gap err=%b done=%b det_rst=%b busy=%b want 1 1 1 0", err, done, det_rst, busy);
    end
    checks++;
    if (match_count !== CW'(exp_count(6))) begin
      errors++;
      $display("FAIL gap_count got %0d want %0d", match_count, exp_count(6));
    end
    tick();
    checks++;
    if (done !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL gap_hold done=%b err=%b want 0 1", done, err);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || match_count !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_restart err=%b mc=%0d busy=%b want 0 0 1", err, match_count, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || det_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_wait busy=%b done=%b det_rst=%b want 0 0 1", busy, done, det_rst);
    end
  endtask

  task automatic test_abort();
    load_frame(12'b110101100000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1; bit_in = fb[i];
      tick();
    end
    bit_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || det_rst !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_run busy=%b done=%b det_rst=%b err=%b want 0 0 1 0", busy, done, det_rst, err);
    end
    checks++;
    if (match_count !== CW'(exp_count(7))) begin
      errors++;
      $display("FAIL abort_count got %0d want %0d", match_count, exp_count(7));
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_nodone done=%b want 0", done);
    end
    // Abort during the drain cycle suppresses done.
    load_frame(12'b110101110101);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < int'(FL); i++) begin
      bit_valid = 1'b1; bit_in = fb[i];
      tick();
    end
    bit_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || det_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_drain done=%b busy=%b det_rst=%b want 0 0 1", done, busy, det_rst);
    end
  endtask

  task automatic test_async_reset();
    load_frame(12'b110101100000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1; bit_in = fb[i];
      tick();
    end
    bit_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (match_count !== '0 || det_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset mc=%0d det_rst=%b busy=%b done=%b want 0 1 0 0", match_count, det_rst, busy, done);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    test_reset();
    test_frames();
    test_random();
    test_gap();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
